// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite drawing blocks: FSM state encoding and
// default screen/framebuffer geometry.
package sprite_pkg;

    localparam int unsigned SCR_W_DEF    = 800;
    localparam int unsigned SCR_H_DEF    = 480;
    localparam int unsigned FB_ADDRW_DEF = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_step.sv
// Fixed-point source-coordinate stepper for one axis: accumulates the step,
// converts to an integer source index, clamps to the sprite and mirrors.
module sprite_step #(
    parameter int unsigned STEPW = 12,
    parameter int unsigned ACCW  = 22,
    parameter int unsigned FRACW = 4,
    parameter int unsigned SPR_N = 16,
    parameter int unsigned IDXW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [STEPW-1:0] i_step,
    input  logic             i_flip,
    output logic [IDXW-1:0]  o_idx_c
);

    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] w_int;
    logic [IDXW-1:0] w_clamp;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_adv) begin
            r_acc <= r_acc + ACCW'(i_step);
        end
    end

    // Index is combinational off the accumulator so it is ready in the issue cycle
    always_comb begin
        w_int   = r_acc >> FRACW;
        w_clamp = w_int[IDXW-1:0];
        if (w_int > ACCW'(SPR_N - 1)) begin
            w_clamp = IDXW'(SPR_N - 1);
        end
        o_idx_c = i_flip ? (IDXW'(SPR_N - 1) - w_clamp) : w_clamp;
    end

endmodule

// File: rtl/sprite_scaler.sv
// Scaled sprite blitter: walks destination pixels row-major, fetches the
// matching sprite texel from a synchronous ROM and writes visible pixels out.
module sprite_scaler
    import sprite_pkg::*;
#(
    parameter int unsigned CORDW     = 10,
    parameter int unsigned SPR_W     = 16,
    parameter int unsigned SPR_H     = 16,
    parameter int unsigned SPR_DATAW = 4,
    parameter int unsigned SCR_W     = SCR_W_DEF,
    parameter int unsigned SCR_H     = SCR_H_DEF,
    parameter int unsigned FB_ADDRW  = FB_ADDRW_DEF,
    parameter int unsigned FRACW     = 4,
    parameter int unsigned TRANSP    = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic signed [CORDW:0]              pos_x,
    input  logic signed [CORDW:0]              pos_y,
    input  logic        [CORDW-1:0]            dst_w,
    input  logic        [CORDW-1:0]            dst_h,
    input  logic        [8+FRACW-1:0]          step_x,
    input  logic        [8+FRACW-1:0]          step_y,
    input  logic                               flip_x,
    input  logic                               flip_y,
    output logic [$clog2(SPR_W*SPR_H)-1:0]     rom_addr,
    output logic                               rom_en,
    input  logic        [SPR_DATAW-1:0]        rom_data,
    output logic        [FB_ADDRW-1:0]         fb_addr,
    output logic        [SPR_DATAW-1:0]        fb_data,
    output logic                               fb_valid,
    input  logic                               fb_ready,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned STEPW  = 8 + FRACW;
    localparam int unsigned ACCW   = 8 + FRACW + CORDW;
    localparam int unsigned ROMAW  = $clog2(SPR_W * SPR_H);
    localparam int unsigned IDXW_X = $clog2(SPR_W);
    localparam int unsigned IDXW_Y = $clog2(SPR_H);
    localparam int unsigned DW     = CORDW + 2;

    state_t r_state, w_next;
    logic   r_busy, r_done;

    logic signed [CORDW:0] r_pos_x, r_pos_y;
    logic [CORDW-1:0]      r_dst_w, r_dst_h, r_ox, r_oy;
    logic [STEPW-1:0]      r_step_x, r_step_y;
    logic                  r_flip_x, r_flip_y;

    logic                  r_rom_en, r_s0_inb, r_s1_vld, r_s1_inb, r_fb_valid;
    logic [ROMAW-1:0]      r_rom_addr;
    logic [FB_ADDRW-1:0]   r_s0_fba, r_s1_fba, r_fb_addr;
    logic [SPR_DATAW-1:0]  r_fb_data;

    logic                  w_stall, w_accept, w_issue, w_last_x, w_last_y, w_inb, w_pix;
    logic [IDXW_X-1:0]     w_idx_x;
    logic [IDXW_Y-1:0]     w_idx_y;
    logic signed [DW-1:0]  w_dx, w_dy;
    logic [FB_ADDRW-1:0]   w_fba;
    logic [ROMAW-1:0]      w_rom_addr;

    assign w_stall  = r_fb_valid && !fb_ready;
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_issue  = (r_state == ST_RUN) && !w_stall;
    assign w_last_x = (r_ox == r_dst_w - CORDW'(1));
    assign w_last_y = (r_oy == r_dst_h - CORDW'(1));

    // Destination coordinate, visibility and framebuffer address of the pixel being issued
    assign w_dx  = DW'(r_pos_x) + $signed(DW'(r_ox));
    assign w_dy  = DW'(r_pos_y) + $signed(DW'(r_oy));
    assign w_inb = !w_dx[DW-1] && (w_dx[DW-2:0] < (DW-1)'(SCR_W))
                && !w_dy[DW-1] && (w_dy[DW-2:0] < (DW-1)'(SCR_H));
    assign w_fba = FB_ADDRW'(w_dy[DW-2:0]) * FB_ADDRW'(SCR_W) + FB_ADDRW'(w_dx[DW-2:0]);
    assign w_rom_addr = ROMAW'(w_idx_y) * ROMAW'(SPR_W) + ROMAW'(w_idx_x);
    assign w_pix = r_s1_vld && r_s1_inb && (rom_data != SPR_DATAW'(TRANSP));

    sprite_step #(
        .STEPW(STEPW), .ACCW(ACCW), .FRACW(FRACW), .SPR_N(SPR_W), .IDXW(IDXW_X)
    ) u_step_x (
        .clk(clk), .rst(rst),
        .i_clr(w_accept || (w_issue && w_last_x)),
        .i_adv(w_issue && !w_last_x),
        .i_step(r_step_x), .i_flip(r_flip_x), .o_idx_c(w_idx_x)
    );

    sprite_step #(
        .STEPW(STEPW), .ACCW(ACCW), .FRACW(FRACW), .SPR_N(SPR_H), .IDXW(IDXW_Y)
    ) u_step_y (
        .clk(clk), .rst(rst),
        .i_clr(w_accept),
        .i_adv(w_issue && w_last_x),
        .i_step(r_step_y), .i_flip(r_flip_y), .o_idx_c(w_idx_y)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ((dst_w == '0) || (dst_h == '0)) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_issue && w_last_x && w_last_y) w_next = ST_FLUSH;
            ST_FLUSH: if (!r_rom_en && !r_s1_vld && !w_stall) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Draw parameters are captured once so the caller may change them mid-draw
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos_x  <= '0;
            r_pos_y  <= '0;
            r_dst_w  <= '0;
            r_dst_h  <= '0;
            r_step_x <= '0;
            r_step_y <= '0;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
        end else if (w_accept) begin
            r_pos_x  <= pos_x;
            r_pos_y  <= pos_y;
            r_dst_w  <= dst_w;
            r_dst_h  <= dst_h;
            r_step_x <= step_x;
            r_step_y <= step_y;
            r_flip_x <= flip_x;
            r_flip_y <= flip_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_ox <= '0;
            r_oy <= '0;
        end else if (w_issue) begin
            if (w_last_x) begin
                r_ox <= '0;
                r_oy <= r_oy + CORDW'(1);
            end else begin
                r_ox <= r_ox + CORDW'(1);
            end
        end
    end

    // Stage 0 issues the ROM read; the ROM answers while stage 1 holds the pixel metadata
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_s0_inb   <= 1'b0;
            r_s0_fba   <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_inb   <= 1'b0;
            r_s1_fba   <= '0;
            r_fb_valid <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
        end else if (!w_stall) begin
            r_rom_en <= w_issue;
            if (w_issue) begin
                r_rom_addr <= w_rom_addr;
                r_s0_inb   <= w_inb;
                r_s0_fba   <= w_fba;
            end
            r_s1_vld   <= r_rom_en;
            r_s1_inb   <= r_s0_inb;
            r_s1_fba   <= r_s0_fba;
            r_fb_valid <= w_pix;
            if (w_pix) begin
                r_fb_addr <= r_s1_fba;
                r_fb_data <= rom_data;
            end
        end
    end

    // ROM enable drops during a stall so the ROM output holds the pending texel
    assign rom_en   = r_rom_en && !w_stall;
    assign rom_addr = r_rom_addr;
    assign fb_valid = r_fb_valid;
    assign fb_addr  = r_fb_addr;
    assign fb_data  = r_fb_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
